// File: rtl/pulse_counter_pkg.sv
// Shared constants and helpers for the up/down pulse counter.
package pulse_counter_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DN    = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Ceiling log2; used to size the prescaler register.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pulse_counter_mod_tick_gen.sv
// Prescaler: emits one tick every PRESC enabled clocks; holds while en is low.
module tick_gen
    import pulse_counter_pkg::*;
#(
    parameter int PRESC = 1,
    parameter int PW    = (clog2(PRESC) > 1) ? clog2(PRESC) : 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam logic [PW-1:0] P_LAST = PW'(PRESC - 1);

    logic [PW-1:0] p;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p <= '0;
        end else if (en) begin
            p <= (p == P_LAST) ? '0 : p + 1'b1;
        end
    end

    // Gated by reset so the strobe drops as soon as reset is asserted.
    assign tick = en & ~reset & (p == P_LAST);

endmodule

// File: rtl/pulse_counter_mod.sv
// Up/down pulse counter with runtime modulus, wrap/saturate, load and terminal-count pulse.
module pulse_counter_mod
    import pulse_counter_pkg::*;
#(
    parameter int N     = 8,
    parameter int PRESC = 1,
    parameter int PW    = (clog2(PRESC) > 1) ? clog2(PRESC) : 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         up_dn,
    input  logic         sat,
    input  logic         load,
    input  logic [N-1:0] d,
    input  logic [N-1:0] mod_max,
    output logic [N-1:0] q,
    output logic         tc,
    output logic         tick
);

    logic         step;
    logic [N-1:0] q_next;
    logic         tc_next;

    tick_gen #(
        .PRESC (PRESC),
        .PW    (PW)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .tick  (tick)
    );

    assign step = tick & ~load;

    always_comb begin
        q_next  = q;
        tc_next = 1'b0;
        if (load) begin
            q_next = (d > mod_max) ? mod_max : d;
        end else if (step) begin
            if (up_dn == DIR_UP) begin
                if (q >= mod_max) begin
                    tc_next = 1'b1;
                    q_next  = (sat == MODE_SAT) ? mod_max : '0;
                end else begin
                    q_next = q + 1'b1;
                end
            end else begin
                // A value stranded above a lowered modulus snaps back to the top.
                if (q == '0) begin
                    tc_next = 1'b1;
                    q_next  = (sat == MODE_SAT) ? '0 : mod_max;
                end else if (q > mod_max) begin
                    q_next = mod_max;
                end else begin
                    q_next = q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q  <= '0;
            tc <= 1'b0;
        end else begin
            q  <= q_next;
            tc <= tc_next;
        end
    end

endmodule
